// File: rtl/vram_arb_pkg.sv
// Shared definitions for the VRAM arbiter: arbitration modes, lock states, tag sizing.
`default_nettype none

package vram_arb_pkg;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_e;

    // Tag width for a port index; never narrower than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vram_read_pipe.sv
// Tag/valid shift register that tracks in-flight VRAM reads until their data is due.
`default_nettype none

module vram_read_pipe #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    output logic [TAG_W-1:0] out_tag_o
);

    logic [DEPTH-1:0] valid_q;
    logic [TAG_W-1:0] tag_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
        end else begin
            valid_q <= {valid_q[DEPTH-2:0], in_valid_i};
            tag_q[0] <= in_tag_i;
            for (int i = 1; i < DEPTH; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign out_valid_o = valid_q[DEPTH-1];
    assign out_tag_o   = tag_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/vram_arbiter.sv
// Multi-port VRAM arbiter: round-robin or fixed-priority pick, burst lock,
// registered VRAM bus and tag-routed read-data return.
`default_nettype none

module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int NUM_PORTS    = 2,
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 1,
    parameter int ARB_MODE     = 0
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_PORTS-1:0]                req,
    input  logic [NUM_PORTS-1:0]                rd,
    input  logic [NUM_PORTS-1:0]                wr,
    input  logic [NUM_PORTS-1:0]                lock,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]   be,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]     wdata,
    output logic [NUM_PORTS-1:0]                gnt,
    output logic [NUM_PORTS-1:0]                rvalid,
    output logic [DATA_WIDTH-1:0]               rdata,
    output logic                                err,
    output logic                                vram_en,
    output logic                                vram_rd,
    output logic                                vram_wr,
    output logic [DATA_WIDTH/8-1:0]             vram_be,
    output logic [ADDR_WIDTH-1:0]               vram_addr,
    output logic [DATA_WIDTH-1:0]               vram_data_out,
    input  logic [DATA_WIDTH-1:0]               vram_data_in
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int TAG_W = clog2(NUM_PORTS);

    lock_state_e            state_q, state_d;
    logic [TAG_W-1:0]       owner_q, owner_d;
    logic [TAG_W-1:0]       last_q, last_d;
    logic [NUM_PORTS-1:0]   eligible;
    logic [TAG_W-1:0]       sel;
    logic [TAG_W-1:0]       probe_idx;
    int                     scan_idx;
    logic                   found;
    logic                   accept;
    logic                   sel_legal;

    logic                   vram_en_q, vram_rd_q, vram_wr_q;
    logic [BE_W-1:0]        vram_be_q;
    logic [ADDR_WIDTH-1:0]  vram_addr_q;
    logic [DATA_WIDTH-1:0]  vram_dout_q;
    logic                   err_q;
    logic [NUM_PORTS-1:0]   rvalid_q;
    logic [DATA_WIDTH-1:0]  rdata_q;

    logic                   pipe_valid;
    logic [TAG_W-1:0]       pipe_tag;

    // Pick logic: while locked only the owner is eligible.
    always_comb begin
        eligible  = req;
        found     = 1'b0;
        sel       = '0;
        scan_idx  = 0;
        probe_idx = '0;
        if (state_q == ST_LOCKED) begin
            eligible          = '0;
            eligible[owner_q] = req[owner_q];
        end
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (ARB_MODE == ARB_FIXED) scan_idx = k;
            else                       scan_idx = (int'(last_q) + 1 + k) % NUM_PORTS;
            probe_idx = TAG_W'(scan_idx);
            if (!found && eligible[probe_idx]) begin
                found = 1'b1;
                sel   = probe_idx;
            end
        end
    end

    assign accept    = found & ~reset;
    assign sel_legal = rd[sel] ^ wr[sel];
    assign gnt       = accept ? (NUM_PORTS'(1) << sel) : '0;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = accept ? sel : last_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && lock[sel]) begin
                    state_d = ST_LOCKED;
                    owner_d = sel;
                end
            end
            ST_LOCKED: begin
                if (!req[owner_q])              state_d = ST_IDLE;
                else if (accept && !lock[sel])  state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            last_q  <= TAG_W'(NUM_PORTS - 1);
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    // Bus register: one VRAM cycle per accepted legal request, otherwise all zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            vram_en_q   <= 1'b0;
            vram_rd_q   <= 1'b0;
            vram_wr_q   <= 1'b0;
            vram_be_q   <= '0;
            vram_addr_q <= '0;
            vram_dout_q <= '0;
            err_q       <= 1'b0;
        end else begin
            if (accept && sel_legal) begin
                vram_en_q   <= 1'b1;
                vram_rd_q   <= rd[sel];
                vram_wr_q   <= wr[sel];
                vram_be_q   <= be[int'(sel)*BE_W +: BE_W];
                vram_addr_q <= addr[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
                vram_dout_q <= wdata[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                vram_en_q   <= 1'b0;
                vram_rd_q   <= 1'b0;
                vram_wr_q   <= 1'b0;
                vram_be_q   <= '0;
                vram_addr_q <= '0;
                vram_dout_q <= '0;
            end
            if (accept && !sel_legal) err_q <= 1'b1;
        end
    end

    vram_read_pipe #(
        .DEPTH (READ_LATENCY + 1),
        .TAG_W (TAG_W)
    ) u_read_pipe (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (accept & sel_legal & rd[sel]),
        .in_tag_i    (sel),
        .out_valid_o (pipe_valid),
        .out_tag_o   (pipe_tag)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= pipe_valid ? (NUM_PORTS'(1) << pipe_tag) : '0;
            if (pipe_valid) rdata_q <= vram_data_in;
        end
    end

    assign rvalid        = rvalid_q;
    assign rdata         = rdata_q;
    assign err           = err_q;
    assign vram_en       = vram_en_q;
    assign vram_rd       = vram_rd_q;
    assign vram_wr       = vram_wr_q;
    assign vram_be       = vram_be_q;
    assign vram_addr     = vram_addr_q;
    assign vram_data_out = vram_dout_q;

endmodule

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: a 3-port round-robin instance plus a
// 3-port fixed-priority instance with READ_LATENCY=3.
`default_nettype none

module tb_vram_arbiter;

    logic        clk;
    logic        reset, reset2;
    logic [2:0]  req, rd, wr, lock;
    logic [2:0]  req2, rd2, wr2, lock2;
    logic [5:0]  be;
    logic [47:0] addr, wdata;

    logic [2:0]  gnt, rvalid;
    logic [15:0] rdata;
    logic        err, ven, vrd, vwr;
    logic [1:0]  vbe;
    logic [15:0] vaddr, vdout;
    logic [15:0] vdin = '0;

    logic [2:0]  f_gnt, f_rvalid;
    logic [15:0] f_rdata;
    logic        f_err, f_ven, f_vrd, f_vwr;
    logic [1:0]  f_vbe;
    logic [15:0] f_vaddr, f_vdout;
    logic [15:0] f_vdin;
    assign f_vdin = 16'hBEEF;

    int checks   = 0;
    int failures = 0;
    logic exp_err = 1'b0;

    typedef struct packed {
        logic        rdb;
        logic        wrb;
        logic [1:0]  be;
        logic [15:0] a;
        logic [15:0] d;
    } bus_t;
    typedef struct packed {
        logic [2:0]  oh;
        logic [15:0] d;
    } ret_t;
    bus_t bus_q[$];
    ret_t ret_q[$];

    localparam logic [47:0] A0 = {16'h0200, 16'h0010, 16'h0100};
    localparam logic [47:0] A1 = {16'h0200, 16'h0011, 16'h0100};

    vram_arbiter #(
        .NUM_PORTS(3), .ADDR_WIDTH(16), .DATA_WIDTH(16), .READ_LATENCY(1), .ARB_MODE(0)
    ) u_dut (
        .clk(clk), .reset(reset), .req(req), .rd(rd), .wr(wr), .lock(lock),
        .be(be), .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid),
        .rdata(rdata), .err(err), .vram_en(ven), .vram_rd(vrd), .vram_wr(vwr),
        .vram_be(vbe), .vram_addr(vaddr), .vram_data_out(vdout), .vram_data_in(vdin)
    );

    vram_arbiter #(
        .NUM_PORTS(3), .ADDR_WIDTH(16), .DATA_WIDTH(16), .READ_LATENCY(3), .ARB_MODE(1)
    ) u_dut_fp (
        .clk(clk), .reset(reset2), .req(req2), .rd(rd2), .wr(wr2), .lock(lock2),
        .be(be), .addr(addr), .wdata(wdata), .gnt(f_gnt), .rvalid(f_rvalid),
        .rdata(f_rdata), .err(f_err), .vram_en(f_ven), .vram_rd(f_vrd), .vram_wr(f_vwr),
        .vram_be(f_vbe), .vram_addr(f_vaddr), .vram_data_out(f_vdout), .vram_data_in(f_vdin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        case (a)
            16'h0010: return 16'hA5A5;
            16'h0011: return 16'h5A5A;
            default:  return a ^ 16'hC3C3;
        endcase
    endfunction

    // VRAM model with one cycle of read latency.
    always @(posedge clk) vdin <= (ven && vrd) ? mem_word(vaddr) : 16'h0000;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step(input logic [2:0] r, input logic [2:0] rdv, input logic [2:0] wrv,
                        input logic [2:0] lk, input logic [47:0] a, input logic [2:0] exp_g);
        int p;
        @(negedge clk);
        req = r; rd = rdv; wr = wrv; lock = lk; addr = a;
        #1;
        check("gnt", 64'(gnt), 64'(exp_g));
        check("err", 64'(err), 64'(exp_err));
        if (exp_g != 3'b000) begin
            p = 0;
            for (int i = 0; i < 3; i++) if (exp_g[i]) p = i;
            if (rdv[p] ^ wrv[p])
                bus_q.push_back({rdv[p], wrv[p], be[p*2 +: 2], a[p*16 +: 16], wdata[p*16 +: 16]});
            if (rdv[p] && !wrv[p])
                ret_q.push_back({exp_g, mem_word(a[p*16 +: 16])});
        end
    endtask

    task automatic fstep(input logic [2:0] r, input logic [2:0] rdv, input logic [2:0] wrv,
                         input logic [2:0] exp_g);
        @(negedge clk);
        req2 = r; rd2 = rdv; wr2 = wrv; lock2 = 3'b000;
        #1;
        check("fp_gnt", 64'(f_gnt), 64'(exp_g));
    endtask

    // Monitor: pops expectations whenever the DUT presents a bus cycle or read return.
    always @(negedge clk) begin
        bus_t b;
        ret_t rt;
        if (ven) begin
            if (bus_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL vram_bus_unexpected actual=%h required=none", {vrd, vwr, vbe, vaddr, vdout});
            end else begin
                b = bus_q.pop_front();
                check("vram_bus", 64'({vrd, vwr, vbe, vaddr, vdout}), 64'(b));
            end
        end else begin
            check("vram_idle", 64'({vrd, vwr, vbe, vaddr, vdout}), 64'd0);
        end
        if (|rvalid) begin
            if (ret_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL rvalid_unexpected actual=%b required=000", rvalid);
            end else begin
                rt = ret_q.pop_front();
                check("rvalid_rdata", 64'({rvalid, rdata}), 64'(rt));
            end
        end
        if (|f_rvalid) begin
            checks++; failures++;
            $display("FAIL fp_rvalid_unexpected actual=%b required=000", f_rvalid);
        end
    end

    initial begin
        reset = 1'b1; reset2 = 1'b1;
        req = '0; rd = '0; wr = '0; lock = '0;
        req2 = '0; rd2 = '0; wr2 = '0; lock2 = '0;
        be = 6'b10_11_01;
        addr = A0;
        wdata = {16'h3333, 16'h2222, 16'h1111};
        repeat (3) @(negedge clk);
        reset = 1'b0; reset2 = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            step(3'b000, 3'b000, 3'b000, 3'b000, A0, 3'b000);
            check("idle_outs", 64'({rvalid, rdata, err, ven}), 64'd0);
        end

        // Round-robin over three reading ports
        step(3'b111, 3'b111, 3'b000, 3'b000, A0, 3'b001);
        step(3'b111, 3'b111, 3'b000, 3'b000, A0, 3'b010);
        step(3'b111, 3'b111, 3'b000, 3'b000, A0, 3'b100);
        step(3'b111, 3'b111, 3'b000, 3'b000, A0, 3'b001);
        step(3'b000, 3'b000, 3'b000, 3'b000, A0, 3'b000);

        // Writes continue the rotation from port 1
        step(3'b110, 3'b000, 3'b110, 3'b000, A0, 3'b010);
        step(3'b110, 3'b000, 3'b110, 3'b000, A0, 3'b100);
        step(3'b000, 3'b000, 3'b000, 3'b000, A0, 3'b000);

        // Locked burst on port 1; port 0 stalls until the unlock grant
        step(3'b010, 3'b010, 3'b000, 3'b010, A0, 3'b010);
        step(3'b011, 3'b011, 3'b000, 3'b000, A1, 3'b010);
        step(3'b001, 3'b001, 3'b000, 3'b000, A1, 3'b001);

        // Owner dropping req releases the lock without a grant that cycle
        step(3'b100, 3'b000, 3'b100, 3'b100, A0, 3'b100);
        step(3'b001, 3'b001, 3'b000, 3'b000, A0, 3'b000);
        step(3'b001, 3'b001, 3'b000, 3'b000, A0, 3'b001);
        step(3'b000, 3'b000, 3'b000, 3'b000, A0, 3'b000);

        // Illegal requests: granted, no bus cycle, sticky err
        step(3'b001, 3'b001, 3'b001, 3'b000, A0, 3'b001);
        exp_err = 1'b1;
        step(3'b100, 3'b000, 3'b000, 3'b000, A0, 3'b100);
        for (int i = 0; i < 4; i++) step(3'b000, 3'b000, 3'b000, 3'b000, A0, 3'b000);

        // Reset mid-lock releases the lock and clears err
        step(3'b010, 3'b000, 3'b010, 3'b010, A0, 3'b010);
        step(3'b010, 3'b000, 3'b010, 3'b010, A0, 3'b010);
        @(negedge clk);
        reset = 1'b1; req = '0; rd = '0; wr = '0; lock = '0;
        @(negedge clk);
        reset = 1'b0;
        exp_err = 1'b0;
        step(3'b001, 3'b000, 3'b001, 3'b000, A0, 3'b001);
        step(3'b011, 3'b000, 3'b011, 3'b000, A0, 3'b010);
        for (int i = 0; i < 3; i++) step(3'b000, 3'b000, 3'b000, 3'b000, A0, 3'b000);

        // Fixed priority: port 1 always beats port 2
        for (int i = 0; i < 4; i++) fstep(3'b110, 3'b000, 3'b110, 3'b010);
        fstep(3'b000, 3'b000, 3'b000, 3'b000);

        // READ_LATENCY=3 read dropped by reset at T+2
        fstep(3'b001, 3'b001, 3'b000, 3'b001);
        fstep(3'b000, 3'b000, 3'b000, 3'b000);
        @(negedge clk);
        reset2 = 1'b1;
        @(negedge clk);
        reset2 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            check("fp_no_rvalid", 64'(f_rvalid), 64'd0);
        end

        for (int i = 0; i < 20 && (bus_q.size() != 0 || ret_q.size() != 0); i++) @(negedge clk);
        check("queues_empty", 64'(bus_q.size() + ret_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vram_arbiter.md
# vram_arbiter

Parametrised VRAM arbiter that multiplexes NUM_PORTS requesters (renderer, MPU, future blitter/DMA) onto the single external VRAM bus. It replaces the single-bit MPU/renderer VRAM switch with per-cycle round-robin or fixed-priority arbitration, locked bursts, and read-data return routed by port tag. It sits between the top-level VRAM pins and every VRAM client.

## Interface
- NUM_PORTS, 2, number of requesters, 2..8; port 0 is the renderer by convention
- ADDR_WIDTH, 16, VRAM word address width
- DATA_WIDTH, 16, VRAM data width; must be a multiple of 8
- READ_LATENCY, 1, cycles from registered vram_rd to valid vram_data_in, 1..4
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)

Ports (packed buses are port-major; port i occupies slice i):
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  NUM_PORTS  request valid, held with payload until gnt
- rd  in  NUM_PORTS  read request
- wr  in  NUM_PORTS  write request
- lock  in  NUM_PORTS  keep grant on this port after this access
- be  in  NUM_PORTS*DATA_WIDTH/8  byte enables, active high
- addr  in  NUM_PORTS*ADDR_WIDTH  word address
- wdata  in  NUM_PORTS*DATA_WIDTH  write data
- gnt  out  NUM_PORTS  one-hot, combinational; request accepted this cycle
- rvalid  out  NUM_PORTS  one-hot, read data valid for that port
- rdata  out  DATA_WIDTH  shared read data
- err  out  1  sticky: an illegal request was accepted
- vram_en, vram_rd, vram_wr  out  1 each  registered bus strobes, active high
- vram_be  out  DATA_WIDTH/8  registered byte enables, active high
- vram_addr  out  ADDR_WIDTH  registered address
- vram_data_out  out  DATA_WIDTH  registered write data
- vram_data_in  in  DATA_WIDTH  VRAM read data

## Operation
- Exactly one request accepted per cycle; gnt asserted only for a port with req=1.
- Round-robin: search starts at (last_granted+1) mod NUM_PORTS; last_granted updated on every grant.
- Fixed priority: lowest-index requesting port wins; last_granted still tracked for lock.
- Lock: granting a port with lock=1 enters LOCKED(owner). In LOCKED, only owner may be granted; other requests stall. Leaves to IDLE when owner is granted with lock=0, or owner drops req for 1 cycle.
- States: IDLE, LOCKED. Reset -> IDLE.
- Accepted legal request (exactly one of rd/wr): VRAM strobes, be, addr, data loaded next edge, held one cycle; vram_en=0 otherwise with other bus outputs zero.
- Illegal request (rd=wr, both 0 or both 1): granted, no VRAM cycle, no rvalid, err set until reset.
- Read tag (owner index + valid) enters shift pipeline of depth READ_LATENCY+1; on exit, rdata <= vram_data_in sampled that cycle and rvalid[tag] <= 1 for one cycle.
- Write issues no rvalid.

## Timing
- Grant in cycle T; vram_* asserted cycle T+1; rvalid/rdata at cycle T+2+READ_LATENCY (T+3 at default).
- Back-to-back grants every cycle; reads pipelined, rvalid returned in grant order.
- Reset values: gnt 0, rvalid 0, rdata 0, err 0, all vram_* 0, last_granted NUM_PORTS-1 (port 0 first), read pipeline empty.
- Reset mid-operation: in-flight reads dropped, no rvalid produced afterwards, lock released.
- Simultaneous: owner's unlock grant and other requests in same cycle -> others compete from next cycle.
- No requests: last_granted unchanged.

## Structure
- Shared package vram_arb_pkg: ARB_RR/ARB_FIXED mode constants, tag width function clog2(NUM_PORTS).
- Sub-module vram_read_pipe: parametrised tag/valid shift register (depth READ_LATENCY+1, width tag+1).
- Arbiter core (pick logic, lock FSM, bus register) in vram_arbiter.

## Test plan
- Reset, then no req -> all outputs 0 for 10 cycles; err 0.
- NUM_PORTS=3, RR, req=3'b111 held -> gnt sequence 001,010,100,001; vram_addr follows port order one cycle later.
- ARB_MODE=1, req=3'b110 constant -> gnt=010 every cycle; port 2 starved.
- Port 1 lock=1 read at 0x0010, then lock=0 read 0x0011 while port 0 requests -> port 0 stalls until after unlock grant; rvalid[1] at T+3, T+4 with model VRAM data 0xA5A5, 0x5A5A.
- Port 0 req with rd=wr=1 -> gnt, vram_en stays 0, err=1 sticky until reset.
- READ_LATENCY=3, read granted, reset asserted at T+2 -> no rvalid ever; pipeline empty after reset.
